mfe_host: RTL and testbench
===========================

MFE_HOST -- requirements
Module: mfe_host

Interface
REQ-001 SHALL have parameter AW, default 14, meaning pixel address width (128x128 image).
REQ-002 SHALL have parameter DW, default 8, meaning pixel data width.
REQ-003 SHALL have parameter TIMEOUT, default 1000000, meaning maximum RUN cycles before watchdog error.
REQ-004 SHALL have ports, one per line, as follows:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run one frame through the engine.
- ld_en  in  1  source-image load strobe.
- ld_addr  in  AW  source-image load address.
- ld_data  in  DW  source-image load data.
- busy  in  1  engine busy.
- ready  out  1  frame-ready request to engine.
- iaddr  in  AW  engine source-pixel address.
- idata  out  DW  source pixel returned to engine.
- addr  in  AW  engine result-memory address.
- wen  in  1  engine result-memory write enable (1 write, 0 read).
- data_wr  in  DW  engine result write data.
- data_rd  out  DW  result-memory read data to engine.
- hr_addr  in  AW  host result readout address.
- hr_data  out  DW  host result readout data.
- done  out  1  one-cycle pulse on frame completion.
- timeout  out  1  sticky watchdog error.
- wr_count  out  AW+1  count of engine writes in the last or current frame.

Function
REQ-005 SHALL contain a 2^AW x DW source memory and a 2^AW x DW result memory.
REQ-006 SHALL write ld_data to source[ld_addr] on a rising edge with ld_en=1 only in IDLE; ld_en in any other state SHALL be ignored.
REQ-007 SHALL implement the FSM IDLE -> ARM -> REQ -> RUN -> FIN -> IDLE.
REQ-008 IDLE: start=1 SHALL move to ARM, clear wr_count and the watchdog counter, and clear timeout; start in any other state SHALL be ignored.
REQ-009 Simultaneous ld_en and start in IDLE SHALL perform the write and accept the start.
REQ-010 ARM: SHALL wait for busy=0, then go to REQ.
REQ-011 REQ: ready SHALL be 1 in REQ only; on the first cycle busy=1 is sampled, the FSM SHALL go to RUN, so ready drops the next cycle.
REQ-012 RUN: every cycle, idata SHALL be registered as source[iaddr], giving 1-cycle latency; outside RUN, idata SHALL be 0.
REQ-013 RUN: wen=1 SHALL write data_wr to result[addr] at the rising edge and increment wr_count, saturating at 2^AW.
REQ-014 RUN: wen=0 SHALL register data_rd as result[addr] with 1-cycle latency; when wen=1, data_rd SHALL hold its value.
REQ-015 Read-after-write to the same address on the next cycle SHALL return the newly written data.
REQ-016 RUN: busy=0 SHALL move to FIN; FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-017 RUN: the watchdog SHALL count cycles; reaching TIMEOUT SHALL set timeout and force FIN, with done still pulsed.
REQ-018 Outside RUN: wen SHALL be ignored, and hr_data SHALL be registered as result[hr_addr] with 1-cycle latency; in RUN, hr_data SHALL hold.
REQ-019 wr_count SHALL hold its value from FIN until the next accepted start.

Reset
REQ-020 On reset=1 at a rising edge: state IDLE, ready=0, idata=0, data_rd=0, hr_data=0, done=0, timeout=0, wr_count=0, watchdog=0.
REQ-021 Reset mid-frame SHALL abort immediately without a done pulse; memory contents SHALL be preserved (not cleared).

Structure
REQ-022 AW/DW defaults, the FSM state enumeration and the 128x128 image size constants SHALL live in a shared package mfe_pkg.
REQ-023 Both memories SHALL be one sub-module instantiated twice: mfe_dpram (1 write port, 1 registered read port).

Verification
REQ-024 Load source[i]=i[7:0] for i=0..16383; start with a loopback engine model copying source to result -> ready rises in REQ, falls the cycle after busy=1, done pulses once, wr_count=16384, and hr_data at hr_addr=300 is 0x2C.
REQ-025 Engine drives iaddr=5 in RUN with source[5]=0xA7 -> idata=0xA7 exactly one cycle later.
REQ-026 Write addr=10, data 0x3C, then read addr=10 on the next cycle -> data_rd=0x3C one cycle after the read.
REQ-027 TIMEOUT=50, engine holds busy=1 -> timeout=1 after 50 RUN cycles, done pulses, FSM returns to IDLE.
REQ-028 reset=1 in RUN after 100 writes -> no done pulse, wr_count=0, and result contents of earlier writes still readable via hr_addr.
REQ-029 start during RUN, ld_en during RUN, and wen=1 while in IDLE -> all ignored, with source/result memories unchanged.

Source files
------------

// File: rtl/mfe_pkg.sv
// Shared constants and types for the frame-engine host: image geometry,
// default memory geometry and the host controller state encoding.
package mfe_pkg;

    // Source/result image geometry (128x128 pixels, one byte each)
    localparam int IMG_W      = 128;
    localparam int IMG_H      = 128;
    localparam int IMG_PIXELS = IMG_W * IMG_H;

    // Default pixel address and data widths; the address covers one full image
    localparam int MFE_AW = $clog2(IMG_PIXELS);
    localparam int MFE_DW = 8;

    // Default watchdog limit, in RUN cycles
    localparam int MFE_TIMEOUT = 1000000;

    // Host controller states for one frame handshake with the engine
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_REQ,
        ST_RUN,
        ST_FIN
    } mfe_state_t;

endpackage

// File: rtl/mfe_dpram.sv
// Simple dual-port RAM: one synchronous write port and one registered read
// port. The read register only updates when re is high, so the last read
// value is held otherwise. Contents are never cleared by reset.
module mfe_dpram
    import mfe_pkg::*;
#(
    parameter int AW = MFE_AW,
    parameter int DW = MFE_DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port and read-first registered read port share the clock edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mfe_host.sv
// Host-side controller for a pixel-processing engine. Owns the source image
// and result memories, hands a frame to the engine with a ready/busy
// handshake, serves the engine's pixel and result accesses while it runs,
// counts result writes and guards the run with a watchdog.
module mfe_host
    import mfe_pkg::*;
#(
    parameter int AW      = MFE_AW,
    parameter int DW      = MFE_DW,
    parameter int TIMEOUT = MFE_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          busy,
    output logic          ready,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic [AW-1:0] addr,
    input  logic          wen,
    input  logic [DW-1:0] data_wr,
    output logic [DW-1:0] data_rd,
    input  logic [AW-1:0] hr_addr,
    output logic [DW-1:0] hr_data,
    output logic          done,
    output logic          timeout,
    output logic [AW:0]   wr_count
);

    // The watchdog must hold TIMEOUT itself, so size it for TIMEOUT+1 values
    localparam int            WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [AW:0]   WR_MAX  = {1'b1, {AW{1'b0}}};

    mfe_state_t state_q;
    mfe_state_t state_d;

    logic            in_idle;
    logic            in_run;
    logic            start_accept;
    logic            wd_expire;
    logic [WD_W-1:0] wdog;

    logic            src_we;
    logic [DW-1:0]   src_rdata;
    logic            src_vld_q;

    logic            res_we;
    logic            res_re;
    logic [AW-1:0]   res_raddr;
    logic [DW-1:0]   res_rdata;
    logic            eng_rd_q;
    logic            host_rd_q;
    logic [DW-1:0]   data_rd_hold;
    logic [DW-1:0]   hr_hold;

    assign in_idle      = (state_q == ST_IDLE);
    assign in_run       = (state_q == ST_RUN);
    assign start_accept = in_idle && start;

    // Next-state and handshake outputs; a watchdog expiry forces FIN while busy
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        done      = 1'b0;
        wd_expire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!busy) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                ready = 1'b1;
                if (busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!busy) begin
                    state_d = ST_FIN;
                end else if (wdog == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_d   = ST_FIN;
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame bookkeeping: write counter, watchdog and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
            wdog     <= '0;
            timeout  <= 1'b0;
        end else if (start_accept) begin
            wr_count <= '0;
            wdog     <= '0;
            timeout  <= 1'b0;
        end else if (in_run) begin
            wdog <= wdog + WD_W'(1);
            if (wd_expire) begin
                timeout <= 1'b1;
            end
            if (wen && (wr_count != WR_MAX)) begin
                wr_count <= wr_count + (AW+1)'(1);
            end
        end
    end

    // Source image: loaded by the host in IDLE, read by the engine in RUN
    assign src_we = in_idle && ld_en && !reset;

    mfe_dpram #(
        .AW (AW),
        .DW (DW)
    ) u_src_mem (
        .clk   (clk),
        .we    (src_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (in_run),
        .raddr (iaddr),
        .rdata (src_rdata)
    );

    // Result memory: the engine owns the ports in RUN, the host reads otherwise
    assign res_we    = in_run && wen && !reset;
    assign res_re    = in_run ? !wen : 1'b1;
    assign res_raddr = in_run ? addr : hr_addr;

    mfe_dpram #(
        .AW (AW),
        .DW (DW)
    ) u_res_mem (
        .clk   (clk),
        .we    (res_we),
        .waddr (addr),
        .wdata (data_wr),
        .re    (res_re),
        .raddr (res_raddr),
        .rdata (res_rdata)
    );

    // Track which requester issued last cycle's read and keep each side's
    // last visible value so the shared read register can serve both
    always_ff @(posedge clk) begin
        if (reset) begin
            src_vld_q    <= 1'b0;
            eng_rd_q     <= 1'b0;
            host_rd_q    <= 1'b0;
            data_rd_hold <= '0;
            hr_hold      <= '0;
        end else begin
            src_vld_q    <= in_run;
            eng_rd_q     <= in_run && !wen;
            host_rd_q    <= !in_run;
            data_rd_hold <= data_rd;
            hr_hold      <= hr_data;
        end
    end

    assign idata   = (in_run && src_vld_q) ? src_rdata : '0;
    assign data_rd = eng_rd_q  ? res_rdata : data_rd_hold;
    assign hr_data = host_rd_q ? res_rdata : hr_hold;

endmodule

// File: tb/tb_mfe_host.sv
// Directed testbench for mfe_host: full-image loopback frame, pixel and
// result latency, ignored controls, watchdog expiry with write-count
// saturation on a small instance, and mid-frame reset.
module tb_mfe_host;
    import mfe_pkg::*;

    localparam int AW  = 14;
    localparam int DW  = 8;
    localparam int WAW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main instance (default geometry and watchdog)
    logic          start, ld_en, busy, wen;
    logic [AW-1:0] ld_addr, iaddr, addr, hr_addr;
    logic [DW-1:0] ld_data, data_wr;
    logic          ready, done, timeout;
    logic [DW-1:0] idata, data_rd, hr_data;
    logic [AW:0]   wr_count;

    // Small instance with a short watchdog
    logic           w_start, w_ld_en, w_busy, w_wen;
    logic [WAW-1:0] w_ld_addr, w_iaddr, w_addr, w_hr_addr;
    logic [DW-1:0]  w_ld_data, w_data_wr;
    logic           w_ready, w_done, w_timeout;
    logic [DW-1:0]  w_idata, w_data_rd, w_hr_data;
    logic [WAW:0]   w_wr_count;

    int vectors     = 0;
    int miscompares = 0;

    mfe_host u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .busy     (busy),
        .ready    (ready),
        .iaddr    (iaddr),
        .idata    (idata),
        .addr     (addr),
        .wen      (wen),
        .data_wr  (data_wr),
        .data_rd  (data_rd),
        .hr_addr  (hr_addr),
        .hr_data  (hr_data),
        .done     (done),
        .timeout  (timeout),
        .wr_count (wr_count)
    );

    mfe_host #(
        .AW      (WAW),
        .DW      (DW),
        .TIMEOUT (50)
    ) u_wdt (
        .clk      (clk),
        .reset    (reset),
        .start    (w_start),
        .ld_en    (w_ld_en),
        .ld_addr  (w_ld_addr),
        .ld_data  (w_ld_data),
        .busy     (w_busy),
        .ready    (w_ready),
        .iaddr    (w_iaddr),
        .idata    (w_idata),
        .addr     (w_addr),
        .wen      (w_wen),
        .data_wr  (w_data_wr),
        .data_rd  (w_data_rd),
        .hr_addr  (w_hr_addr),
        .hr_data  (w_hr_data),
        .done     (w_done),
        .timeout  (w_timeout),
        .wr_count (w_wr_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the main engine-side inputs for one cycle
    task automatic applyStimulus(input logic b, input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
        busy    = b;
        wen     = w;
        addr    = a;
        data_wr = d;
        tick();
    endtask

    // After start is accepted: ARM, wait for ready, raise busy, enter RUN
    task automatic requestFrame(input string tag);
        int n;
        checkOutput({tag, "_ready_arm"}, 32'(ready), 32'd0);
        n = 0;
        while (!ready && n < 10) begin
            tick();
            n++;
        end
        checkOutput({tag, "_ready_req"}, 32'(ready), 32'd1);
        busy = 1'b1;
        tick();
        checkOutput({tag, "_ready_drop"}, 32'(ready), 32'd0);
    endtask

    task automatic hostRead(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        hr_addr = a;
        tick();
        checkOutput(tag, 32'(hr_data), 32'(exp));
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] stopped");
    end

    initial begin
        int dcount;
        int n;

        reset   = 1'b1;
        start   = 1'b0; ld_en = 1'b0; busy = 1'b0; wen = 1'b0;
        ld_addr = '0; ld_data = '0; iaddr = '0; addr = '0; data_wr = '0; hr_addr = '0;
        w_start = 1'b0; w_ld_en = 1'b0; w_busy = 1'b0; w_wen = 1'b0;
        w_ld_addr = '0; w_ld_data = '0; w_iaddr = '0; w_addr = '0; w_data_wr = '0; w_hr_addr = '0;
        repeat (3) tick();

        // Reset state
        checkOutput("rst_ready",    32'(ready),    32'd0);
        checkOutput("rst_done",     32'(done),     32'd0);
        checkOutput("rst_timeout",  32'(timeout),  32'd0);
        checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
        checkOutput("rst_idata",    32'(idata),    32'd0);
        checkOutput("rst_data_rd",  32'(data_rd),  32'd0);
        checkOutput("rst_hr_data",  32'(hr_data),  32'd0);
        reset = 1'b0;

        // Watchdog on the small instance: busy held, 20 writes saturate at 16
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        n = 0;
        while (!w_ready && n < 10) begin
            tick();
            n++;
        end
        checkOutput("wdt_ready", 32'(w_ready), 32'd1);
        w_busy = 1'b1;
        tick();
        for (int i = 0; i < 49; i++) begin
            w_wen     = (i < 20);
            w_addr    = WAW'(i);
            w_data_wr = DW'(i);
            tick();
        end
        checkOutput("wdt_timeout_early", 32'(w_timeout),  32'd0);
        checkOutput("wdt_done_early",    32'(w_done),     32'd0);
        checkOutput("wdt_wr_sat",        32'(w_wr_count), 32'd16);
        tick();
        checkOutput("wdt_timeout_set", 32'(w_timeout), 32'd1);
        checkOutput("wdt_done_pulse",  32'(w_done),    32'd1);
        tick();
        checkOutput("wdt_done_clear",    32'(w_done),    32'd0);
        checkOutput("wdt_timeout_stick", 32'(w_timeout), 32'd1);
        w_busy  = 1'b0;
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        checkOutput("wdt_idle_restart", 32'(w_timeout),  32'd0);
        checkOutput("wdt_wr_clear",     32'(w_wr_count), 32'd0);

        // Load source[i] = i[7:0]; the last load coincides with start
        for (int i = 0; i < (1 << AW) - 1; i++) begin
            ld_en   = 1'b1;
            ld_addr = AW'(i);
            ld_data = DW'(i);
            tick();
        end
        ld_addr = AW'((1 << AW) - 1);
        ld_data = 8'hFF;
        start   = 1'b1;
        tick();
        ld_en = 1'b0;
        start = 1'b0;
        requestFrame("lb");

        // Loopback engine: read pixel k, write it back one cycle later
        iaddr = '0;
        wen   = 1'b0;
        tick();
        for (int k = 1; k <= (1 << AW); k++) begin
            if (k == 200) checkOutput("lb_idata_stream", 32'(idata), 32'hC7);
            iaddr = (k < (1 << AW)) ? AW'(k) : '0;
            applyStimulus(1'b1, 1'b1, AW'(k - 1), idata);
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            dcount += int'(done);
            tick();
        end
        checkOutput("lb_done_once", 32'(dcount),   32'd1);
        checkOutput("lb_wr_count",  32'(wr_count), 32'h4000);
        checkOutput("lb_timeout",   32'(timeout),  32'd0);
        hostRead("lb_hr_300",   AW'(300),   8'h2C);
        hostRead("lb_hr_last",  AW'(16383), 8'hFF);
        hostRead("lb_hr_0",     AW'(0),     8'h00);

        // Pixel latency, read-after-write, ignored start/ld_en in RUN
        ld_en   = 1'b1;
        ld_addr = AW'(5);
        ld_data = 8'hA7;
        tick();
        ld_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        requestFrame("f2");
        iaddr   = AW'(5);
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_addr = AW'(7);
        ld_data = 8'hEE;
        hr_addr = AW'(16383);
        applyStimulus(1'b1, 1'b1, AW'(10), 8'h3C);
        checkOutput("f2_idata_lat", 32'(idata), 32'hA7);
        start = 1'b0;
        ld_en = 1'b0;
        applyStimulus(1'b1, 1'b0, AW'(10), 8'h00);
        checkOutput("f2_raw_data_rd", 32'(data_rd), 32'h3C);
        applyStimulus(1'b1, 1'b1, AW'(11), 8'h99);
        checkOutput("f2_data_rd_hold", 32'(data_rd), 32'h3C);
        checkOutput("f2_hr_hold",      32'(hr_data), 32'h00);
        applyStimulus(1'b0, 1'b0, AW'(10), 8'h00);
        checkOutput("f2_done",     32'(done),     32'd1);
        checkOutput("f2_wr_count", 32'(wr_count), 32'd2);
        tick();
        checkOutput("f2_done_clear", 32'(done),  32'd0);
        checkOutput("f2_idata_idle", 32'(idata), 32'd0);

        // wen in IDLE must not write
        hr_addr = AW'(20);
        applyStimulus(1'b0, 1'b1, AW'(20), 8'h55);
        wen = 1'b0;
        tick();
        checkOutput("idle_wen_ignored", 32'(hr_data), 32'h14);
        hostRead("f2_hr_10", AW'(10), 8'h3C);
        hostRead("f2_hr_11", AW'(11), 8'h99);

        // Mid-frame reset after 100 writes
        start = 1'b1;
        tick();
        start = 1'b0;
        requestFrame("f3");
        iaddr = AW'(7);
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("f3_src7_unchanged", 32'(idata), 32'h07);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 1'b1, AW'(1000 + i), DW'(8'h40 + i));
        end
        checkOutput("f3_wr_count_pre", 32'(wr_count), 32'd100);
        wen   = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        busy  = 1'b0;
        checkOutput("f3_rst_done",     32'(done),     32'd0);
        checkOutput("f3_rst_wr_count", 32'(wr_count), 32'd0);
        checkOutput("f3_rst_ready",    32'(ready),    32'd0);
        checkOutput("f3_rst_idata",    32'(idata),    32'd0);
        checkOutput("f3_rst_data_rd",  32'(data_rd),  32'd0);
        checkOutput("f3_rst_hr_data",  32'(hr_data),  32'd0);
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            dcount += int'(done);
            tick();
        end
        checkOutput("f3_no_done", 32'(dcount), 32'd0);
        hostRead("f3_hr_1000", AW'(1000), 8'h40);
        hostRead("f3_hr_1099", AW'(1099), 8'hA3);
        hostRead("f3_hr_300",  AW'(300),  8'h2C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
